// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: PC register and IF/ID pipeline register for a 5-stage MIPS pipeline.
// Combines the hazard unit's load-use stall enables (PCWrite, IfIdWrite) with a downstream
// branch/jump redirect.
// From these it holds or advances the PC, and holds, advances or flushes IF/ID.
// A one-cycle BOOT state after reset presents RESET_PC with a bubble in IF/ID.
// Optional feature: define FETCH_PERF_CNT_EN to add saturating stall/flush counters
// (ports stall_cnt and flush_cnt).
// All outputs are registered; no input reaches an output combinationally.

module fetch_stage_ctrl #(
    parameter int unsigned     AW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          PCWrite,
    input  logic          IfIdWrite,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic [AW-1:0] imem_instr,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] if_id_instr,
    output logic [AW-1:0] if_id_pc4,
    output logic          if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt
`endif
);

    // FSM encoding
    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [AW-1:0] PC_STEP = AW'(4);

    logic [0:0]    r_state;
    logic [0:0]    w_state_d;

    logic [AW-1:0] r_pc;
    logic [AW-1:0] w_pc_d;
    logic [AW-1:0] r_instr;
    logic [AW-1:0] w_instr_d;
    logic [AW-1:0] r_pc4;
    logic [AW-1:0] w_pc4_d;
    logic          r_valid;
    logic          w_valid_d;

    logic          w_is_run;
    logic [AW-1:0] w_pc_plus4;

    assign w_is_run   = (r_state == ST_RUN);
    // Modulo-2^AW increment: the top address wraps to zero.
    assign w_pc_plus4 = r_pc + PC_STEP;

    // Next-state logic: BOOT bubble, then redirect > stall > per-register enables
    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_instr_d = r_instr;
        w_pc4_d   = r_pc4;
        w_valid_d = r_valid;

        if (!w_is_run) begin
            // BOOT: inputs ignored, PC held, IF/ID forced to a bubble.
            w_state_d = ST_RUN;
            w_instr_d = '0;
            w_pc4_d   = '0;
            w_valid_d = 1'b0;
        end else if (redirect) begin
            // A taken redirect overrides any stall and squashes the wrong-path fetch.
            w_pc_d    = redirect_pc;
            w_instr_d = '0;
            w_pc4_d   = '0;
            w_valid_d = 1'b0;
        end else begin
            // Each register follows its own enable; both low is a full stall.
            if (PCWrite) begin
                w_pc_d = w_pc_plus4;
            end
            if (IfIdWrite) begin
                w_instr_d = imem_instr;
                w_pc4_d   = w_pc_plus4;
                w_valid_d = 1'b1;
            end
        end
    end

    // State, PC and IF/ID registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            r_instr <= w_instr_d;
            r_pc4   <= w_pc4_d;
            r_valid <= w_valid_d;
        end
    end

    assign pc          = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc4   = r_pc4;
    assign if_id_valid = r_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_stall_evt;
    logic        w_flush_evt;

    // A redirect during a stall counts only as a flush.
    assign w_stall_evt = w_is_run && !redirect && !PCWrite;
    assign w_flush_evt = w_is_run && redirect;

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_flush_evt && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: doc/fetch_stage_ctrl.md
Name: fetch_stage_ctrl

Overview:
- PC register and IF/ID pipeline register for the 5-stage MIPS pipeline.
- Acts on the load-use stall outputs of the hazard detection unit (PCWrite, IfIdWrite) and on taken branch/jump redirects resolved downstream.
- Converts them into a held or advanced PC, and into a held, advanced or flushed IF/ID register.
- Sits between instruction memory and the ID stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- AW, 32, PC and instruction width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- PCWrite  in  1  1 = PC may advance; 0 = hold (load-use stall).
- IfIdWrite  in  1  1 = IF/ID may load; 0 = hold.
- redirect  in  1  taken branch/jump this cycle.
- redirect_pc  in  AW  target address, valid when redirect=1.
- imem_instr  in  AW  instruction read from imem at pc.
- pc  out  AW  current fetch address to imem.
- if_id_instr  out  AW  instruction presented to ID.
- if_id_pc4  out  AW  PC+4 of that instruction.
- if_id_valid  out  1  1 = if_id_instr is a real instruction; 0 = bubble.

Behaviour:
- Reset, async on rst high: pc=RESET_PC, if_id_instr=0 (nop), if_id_pc4=0, if_id_valid=0, FSM=BOOT.
- FSM state BOOT:
  - Lasts exactly one clock after rst deasserts.
  - pc held; IF/ID loads nop with valid=0.
  - Next state is RUN unconditionally. redirect, PCWrite and IfIdWrite are ignored in BOOT.
- FSM state RUN, evaluated per rising edge in priority order:
  - 1. redirect=1:
    - pc <= redirect_pc.
    - IF/ID flushed: instr=0, pc4=0, valid=0.
    - Applies regardless of PCWrite/IfIdWrite; redirect beats stall.
  - 2. else PCWrite=0 and IfIdWrite=0 (stall): pc and IF/ID hold their values, including valid.
  - 3. else PCWrite=1 and IfIdWrite=1: pc <= pc+4; IF/ID <= {imem_instr, pc+4, valid=1}.
  - 4. Mixed PCWrite≠IfIdWrite:
    - Each register obeys its own enable independently.
    - IF/ID loading with PC held loads the same instruction again; this is legal.
- PC arithmetic: AW-bit modulo, so 32'hFFFF_FFFC+4 wraps to 0. No alignment check; redirect_pc bits [1:0] are passed as given.
- Latency:
  - imem_instr is sampled at the edge ending the cycle in which pc is presented.
  - The instruction appears on if_id_instr one cycle after its pc.
- Re-asserting rst mid-operation returns to BOOT immediately, asynchronously.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output ports stall_cnt[31:0] and flush_cnt[31:0], both reset to 0.
  - stall_cnt increments on each RUN edge where redirect=0 and PCWrite=0.
  - flush_cnt increments on each RUN edge with redirect=1.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, enables=1, imem_instr=pc-dependent pattern:
  - BOOT cycle shows pc=0, valid=0.
  - Then pc goes 4, 8, 12.
  - if_id_instr follows the pc one cycle behind, with if_id_pc4=4, 8, 12 and valid=1.
- Load-use stall with PCWrite=IfIdWrite=0 for 2 cycles at pc=8:
  - pc stays 8 and IF/ID holds the instruction fetched at 4 for both cycles.
  - Release resumes with pc=12.
- Redirect with redirect_pc=32'h40 while PCWrite=0 simultaneously:
  - Next pc=32'h40 and if_id_valid=0, if_id_instr=0.
  - The following cycle IF/ID holds the instruction from 32'h40 with pc4=32'h44.
- Wrap: redirect to 32'hFFFF_FFFC, then run: next pc=0 and if_id_pc4=0 for the wrapped fetch.
- Async reset asserted mid-stall between clock edges: outputs show reset values before the next edge, and a BOOT cycle follows release.
- With FETCH_PERF_CNT_EN: 3 stall cycles and 2 redirects give stall_cnt=3, flush_cnt=2. A redirect during a stall counts only as a flush.
